// File: rtl/fir_pkg.sv
// Shared constants for the low-pass FIR chain and its decimating output stage.
package fir_pkg;

  localparam int unsigned FIR_IN_W     = 32;
  localparam int unsigned FIR_OUT_W    = 16;
  localparam int unsigned FIR_COEF_SUM = 60365;
  localparam int unsigned FIR_SHIFT    = 16;
  localparam int unsigned DECIM_W      = 4;
  localparam int unsigned SAT_CNT_W    = 8;

  // Signed clip limits of the default output width.
  localparam int FIR_SAT_MAX = (1 << (FIR_OUT_W - 1)) - 1;
  localparam int FIR_SAT_MIN = -(1 << (FIR_OUT_W - 1));

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through output FIFO; the caller only pops when non-empty
// and only pushes when not full or popping on the same edge.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int unsigned W     = FIR_OUT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_pop,
  output logic [W-1:0] o_rd_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_decimator.sv
// Decimates the FIR accumulator by M, rounds/saturates kept samples to OUT_W
// bits and hands them downstream through a valid/ready FIFO.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = FIR_IN_W,
  parameter int unsigned OUT_W = FIR_OUT_W,
  parameter int unsigned SHIFT = FIR_SHIFT,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      din,
  input  logic                 din_valid,
  input  logic [DECIM_W-1:0]   decim_m,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN_I = -(1 << (OUT_W - 1));
  localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'(SAT_MAX_I);
  localparam logic signed [IN_W:0] Q_MIN = (IN_W+1)'(SAT_MIN_I);
  localparam logic signed [IN_W:0] RND   = (IN_W+1)'(1) << (SHIFT - 1);

  logic [DECIM_W-1:0]   r_ph;
  logic [OUT_W-1:0]     r_data;
  logic                 r_vld;
  logic                 r_overflow;
  logic [SAT_CNT_W-1:0] r_sat_cnt;

  logic [DECIM_W-1:0]   w_m_new;
  logic                 w_keep;
  logic signed [IN_W:0] w_s;
  logic signed [IN_W:0] w_q;
  logic                 w_hi;
  logic                 w_lo;
  logic [OUT_W-1:0]     w_y;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;

  assign w_m_new = (decim_m == '0) ? DECIM_W'(1) : decim_m;
  assign w_keep  = din_valid && (r_ph == '0);

  // One extra sign bit keeps the rounding add from wrapping.
  assign w_s  = $signed({din[IN_W-1], din}) + RND;
  assign w_q  = w_s >>> SHIFT;
  assign w_hi = (w_q > Q_MAX);
  assign w_lo = (w_q < Q_MIN);
  assign w_y  = w_hi ? OUT_W'(SAT_MAX_I) :
                w_lo ? OUT_W'(SAT_MIN_I) : w_q[OUT_W-1:0];

  // Ratio is latched only on a kept sample so the running phase is never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph <= '0;
    end else if (din_valid) begin
      if (r_ph == '0) r_ph <= w_m_new - DECIM_W'(1);
      else            r_ph <= r_ph - DECIM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= 1'b0;
      r_data    <= '0;
      r_sat_cnt <= '0;
    end else begin
      r_vld <= w_keep;
      if (w_keep) r_data <= w_y;
      if (w_keep && (w_hi || w_lo) && (r_sat_cnt != '1))
        r_sat_cnt <= r_sat_cnt + SAT_CNT_W'(1);
    end
  end

  // A full FIFO still accepts the write when a pop frees a slot on the same edge.
  assign w_pop  = out_valid && out_ready;
  assign w_push = r_vld && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst)                            r_overflow <= 1'b0;
    else if (r_vld && w_full && !w_pop) r_overflow <= 1'b1;
  end

  fir_out_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (r_data),
    .i_pop     (w_pop),
    .o_rd_data (out_data),
    .o_empty   (w_empty),
    .o_full    (w_full)
  );

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;
  assign sat_cnt   = r_sat_cnt;

endmodule
